reg_file_arbiter: RTL and testbench

Two-requester round-robin arbiter and sequencer for the 8x16 register file. It accepts one read or write transaction per grant and drives the register file's WrData/Address/WrEn/RdEn, never asserting WrEn and RdEn together. It returns read data to the owning requester and rejects out-of-range addresses. It sits between two client blocks and a single Reg_File instance.

---
 rtl/reg_file_arbiter_pkg.sv | 16 +
 rtl/reg_file_arbiter_rr_arbiter2.sv | 33 +++
 rtl/reg_file_arbiter.sv | 114 +++++++++++
 tb/tb_reg_file_arbiter.sv | 382 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_arbiter_pkg.sv
// Shared definitions for the two-requester register-file arbiter: FSM states,
// requester count and the owner-id type carried in the command record.
package reg_file_arbiter_pkg;

    localparam int NUM_REQ = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RWAIT = 2'd2,
        ERR   = 2'd3
    } state_t;

    typedef logic [$clog2(NUM_REQ)-1:0] owner_t;

endpackage

// File: rtl/reg_file_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter: combinational grant from the requests and a
// priority pointer that moves to the loser whenever a grant is accepted.
module rr_arbiter2
    import reg_file_arbiter_pkg::*;
(
    input  logic   CLK,
    input  logic   RST,
    input  logic   i_req0,
    input  logic   i_req1,
    input  logic   i_accept,
    output logic   o_gnt0,
    output logic   o_gnt1,
    output owner_t o_winner
);

    owner_t r_ptr;

    always_comb begin
        o_gnt0   = i_accept && i_req0 && (!i_req1 || (r_ptr == owner_t'(0)));
        o_gnt1   = i_accept && i_req1 && (!i_req0 || (r_ptr == owner_t'(1)));
        o_winner = owner_t'(o_gnt1);
    end

    // Pointer lands on the non-winner, so a granted requester waits its turn.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_ptr <= owner_t'(0);
        end else if (o_gnt0 || o_gnt1) begin
            r_ptr <= owner_t'(o_gnt0);
        end
    end

endmodule

// File: rtl/reg_file_arbiter.sv
// Sequences one read/write per grant from two requesters onto a single register
// file port, returning read data or an address error to the owning requester.
module reg_file_arbiter
    import reg_file_arbiter_pkg::*;
#(
    parameter int ADDR_Width = 4,
    parameter int MEM_WIDTH  = 16,
    parameter int MEM_DEPTH  = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  Req0,
    input  logic                  Req1,
    input  logic                  We0,
    input  logic                  We1,
    input  logic [ADDR_Width-1:0] Addr0,
    input  logic [ADDR_Width-1:0] Addr1,
    input  logic [MEM_WIDTH-1:0]  WData0,
    input  logic [MEM_WIDTH-1:0]  WData1,
    output logic                  Gnt0,
    output logic                  Gnt1,
    output logic                  RdValid0,
    output logic                  RdValid1,
    output logic [MEM_WIDTH-1:0]  RdData0,
    output logic [MEM_WIDTH-1:0]  RdData1,
    output logic                  Err0,
    output logic                  Err1,
    input  logic [MEM_WIDTH-1:0]  RF_RdData,
    output logic [MEM_WIDTH-1:0]  RF_WrData,
    output logic [ADDR_Width-1:0] RF_Address,
    output logic                  RF_WrEn,
    output logic                  RF_RdEn
);

    typedef struct packed {
        logic                  we;
        logic [ADDR_Width-1:0] addr;
        logic [MEM_WIDTH-1:0]  wdata;
        owner_t                owner;
    } cmd_t;

    localparam logic [ADDR_Width:0] LP_DEPTH = (ADDR_Width + 1)'(MEM_DEPTH);

    state_t r_state;
    state_t w_state_next;
    cmd_t   r_cmd;
    cmd_t   w_win_cmd;
    owner_t w_winner;
    logic   w_accept;
    logic   w_gnt_any;
    logic   w_addr_bad;

    // Reset gates acceptance so no grant can leak out while RST is low.
    assign w_accept  = (r_state == IDLE) && RST;
    assign w_gnt_any = Gnt0 || Gnt1;

    rr_arbiter2 u_arb (
        .CLK      (CLK),
        .RST      (RST),
        .i_req0   (Req0),
        .i_req1   (Req1),
        .i_accept (w_accept),
        .o_gnt0   (Gnt0),
        .o_gnt1   (Gnt1),
        .o_winner (w_winner)
    );

    always_comb begin
        if (w_winner == owner_t'(1)) begin
            w_win_cmd = '{we: We1, addr: Addr1, wdata: WData1, owner: owner_t'(1)};
        end else begin
            w_win_cmd = '{we: We0, addr: Addr0, wdata: WData0, owner: owner_t'(0)};
        end
        w_addr_bad = ({1'b0, w_win_cmd.addr} >= LP_DEPTH);
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:    if (w_gnt_any) w_state_next = w_addr_bad ? ERR : ISSUE;
            ISSUE:   w_state_next = r_cmd.we ? IDLE : RWAIT;
            RWAIT:   w_state_next = IDLE;
            ERR:     w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= IDLE;
            r_cmd   <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_gnt_any) begin
                r_cmd <= w_win_cmd;
            end
        end
    end

    // All outputs decode straight from the state and command registers.
    always_comb begin
        RF_Address = r_cmd.addr;
        RF_WrData  = r_cmd.wdata;
        RF_WrEn    = (r_state == ISSUE) &&  r_cmd.we;
        RF_RdEn    = (r_state == ISSUE) && !r_cmd.we;
        RdValid0   = (r_state == RWAIT) && (r_cmd.owner == owner_t'(0));
        RdValid1   = (r_state == RWAIT) && (r_cmd.owner == owner_t'(1));
        RdData0    = RdValid0 ? RF_RdData : '0;
        RdData1    = RdValid1 ? RF_RdData : '0;
        Err0       = (r_state == ERR) && (r_cmd.owner == owner_t'(0));
        Err1       = (r_state == ERR) && (r_cmd.owner == owner_t'(1));
    end

endmodule

// File: tb/tb_reg_file_arbiter.sv
// Bench for reg_file_arbiter: a cycle-level transaction model predicts grants,
// register-file strobes and responses, compared against the DUT every cycle.
module tb_reg_file_arbiter;

    localparam int AW    = 4;
    localparam int DW    = 16;
    localparam int DEPTH = 8;
    localparam int MAXC  = 400;

    logic          CLK = 1'b0;
    logic          RST;
    logic          Req0 = 1'b0, Req1 = 1'b0, We0 = 1'b0, We1 = 1'b0;
    logic [AW-1:0] Addr0 = '0, Addr1 = '0;
    logic [DW-1:0] WData0 = '0, WData1 = '0;
    logic          Gnt0, Gnt1, RdValid0, RdValid1, Err0, Err1;
    logic [DW-1:0] RdData0, RdData1;
    logic [DW-1:0] RF_RdData, RF_WrData;
    logic [AW-1:0] RF_Address;
    logic          RF_WrEn, RF_RdEn;

    always #5 CLK = ~CLK;

    reg_file_arbiter #(.ADDR_Width(AW), .MEM_WIDTH(DW), .MEM_DEPTH(DEPTH)) dut (
        .CLK(CLK), .RST(RST),
        .Req0(Req0), .Req1(Req1), .We0(We0), .We1(We1),
        .Addr0(Addr0), .Addr1(Addr1), .WData0(WData0), .WData1(WData1),
        .Gnt0(Gnt0), .Gnt1(Gnt1), .RdValid0(RdValid0), .RdValid1(RdValid1),
        .RdData0(RdData0), .RdData1(RdData1), .Err0(Err0), .Err1(Err1),
        .RF_RdData(RF_RdData), .RF_WrData(RF_WrData), .RF_Address(RF_Address),
        .RF_WrEn(RF_WrEn), .RF_RdEn(RF_RdEn)
    );

    // Register file: synchronous write, registered read, cleared by RST.
    logic [DW-1:0] rf_mem [DEPTH];
    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < DEPTH; i++) rf_mem[i] <= '0;
            RF_RdData <= '0;
        end else begin
            if (RF_WrEn) rf_mem[RF_Address[2:0]] <= RF_WrData;
            if (RF_RdEn) RF_RdData <= rf_mem[RF_Address[2:0]];
        end
    end

    bit both_seen;
    always @(posedge CLK) if (RF_WrEn && RF_RdEn) both_seen <= 1'b1;

    typedef struct {
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            gap;
        bit            withdraw;
    } txn_t;

    typedef struct packed {
        logic          gnt0, gnt1, rdv0, rdv1;
        logic [DW-1:0] rd0, rd1;
        logic          err0, err1, wren, rden;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } cyc_t;

    int            total = 0;
    int            bad = 0;
    logic [DW-1:0] ref_mem [DEPTH];
    int            ref_ptr;
    txn_t          q0[$], q1[$];
    cyc_t          obs_log [MAXC];
    cyc_t          exp_log [MAXC+4];
    int            n_log;
    int            gnt_seq[$];

    function automatic txn_t mk(bit we, int addr, int wdata, int gap, bit wd);
        txn_t t;
        t.we = we; t.addr = AW'(addr); t.wdata = DW'(wdata); t.gap = gap; t.withdraw = wd;
        return t;
    endfunction

    task automatic ref_reset();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        ref_ptr = 0;
    endtask

    // Drives q0/q1 as two requesters and builds expected per-cycle behaviour
    // from the transaction rules: winner selection, fixed latencies, busy time.
    task automatic run();
        txn_t dq0[$], dq1[$], mq0[$], mq1[$];
        txn_t t;
        cyc_t o;
        int   dcnt0, dcnt1, mcnt0, mcnt1, m_free, c, w;
        bit   p0, p1, mp0, mp1, mg0, mg1;
        dq0 = q0; dq1 = q1; mq0 = q0; mq1 = q1;
        for (int i = 0; i < MAXC + 4; i++) exp_log[i] = '0;
        gnt_seq.delete();
        dcnt0 = (dq0.size() > 0) ? dq0[0].gap : 0;
        dcnt1 = (dq1.size() > 0) ? dq1[0].gap : 0;
        mcnt0 = dcnt0; mcnt1 = dcnt1;
        m_free = 0; c = 0;
        while ((dq0.size() > 0 || dq1.size() > 0 || mq0.size() > 0 || mq1.size() > 0
                || c <= m_free) && c < MAXC) begin
            p0 = (dq0.size() > 0) && (dcnt0 == 0);
            p1 = (dq1.size() > 0) && (dcnt1 == 0);
            Req0 = p0; Req1 = p1;
            if (dq0.size() > 0) begin We0 = dq0[0].we; Addr0 = dq0[0].addr; WData0 = dq0[0].wdata; end
            if (dq1.size() > 0) begin We1 = dq1[0].we; Addr1 = dq1[0].addr; WData1 = dq1[0].wdata; end

            mp0 = (mq0.size() > 0) && (mcnt0 == 0);
            mp1 = (mq1.size() > 0) && (mcnt1 == 0);
            mg0 = 1'b0; mg1 = 1'b0;
            if (c >= m_free && (mp0 || mp1)) begin
                w = (mp0 && mp1) ? ref_ptr : (mp0 ? 0 : 1);
                ref_ptr = 1 - w;
                if (w == 0) begin
                    t = mq0.pop_front(); exp_log[c].gnt0 = 1'b1; mg0 = 1'b1;
                    mcnt0 = (mq0.size() > 0) ? mq0[0].gap : 0;
                end else begin
                    t = mq1.pop_front(); exp_log[c].gnt1 = 1'b1; mg1 = 1'b1;
                    mcnt1 = (mq1.size() > 0) ? mq1[0].gap : 0;
                end
                if (int'(t.addr) >= DEPTH) begin
                    if (w == 0) exp_log[c+1].err0 = 1'b1; else exp_log[c+1].err1 = 1'b1;
                    m_free = c + 2;
                end else if (t.we) begin
                    exp_log[c+1].wren  = 1'b1;
                    exp_log[c+1].addr  = t.addr;
                    exp_log[c+1].wdata = t.wdata;
                    ref_mem[t.addr[2:0]] = t.wdata;
                    m_free = c + 2;
                end else begin
                    exp_log[c+1].rden = 1'b1;
                    exp_log[c+1].addr = t.addr;
                    if (w == 0) begin
                        exp_log[c+2].rdv0 = 1'b1; exp_log[c+2].rd0 = ref_mem[t.addr[2:0]];
                    end else begin
                        exp_log[c+2].rdv1 = 1'b1; exp_log[c+2].rd1 = ref_mem[t.addr[2:0]];
                    end
                    m_free = c + 3;
                end
            end
            if (!mg0) begin
                if (mp0 && mq0[0].withdraw) begin
                    void'(mq0.pop_front()); mcnt0 = (mq0.size() > 0) ? mq0[0].gap : 0;
                end else if (!mp0 && mq0.size() > 0 && mcnt0 > 0) mcnt0--;
            end
            if (!mg1) begin
                if (mp1 && mq1[0].withdraw) begin
                    void'(mq1.pop_front()); mcnt1 = (mq1.size() > 0) ? mq1[0].gap : 0;
                end else if (!mp1 && mq1.size() > 0 && mcnt1 > 0) mcnt1--;
            end

            @(negedge CLK);
            o.gnt0 = Gnt0; o.gnt1 = Gnt1; o.rdv0 = RdValid0; o.rdv1 = RdValid1;
            o.rd0 = RdData0; o.rd1 = RdData1; o.err0 = Err0; o.err1 = Err1;
            o.wren = RF_WrEn; o.rden = RF_RdEn;
            o.addr  = (RF_WrEn || RF_RdEn) ? RF_Address : '0;
            o.wdata = RF_WrEn ? RF_WrData : '0;
            obs_log[c] = o;
            if (Gnt0) gnt_seq.push_back(0);
            if (Gnt1) gnt_seq.push_back(1);

            if (Gnt0 && dq0.size() > 0) begin
                void'(dq0.pop_front()); dcnt0 = (dq0.size() > 0) ? dq0[0].gap : 0;
            end else if (p0 && dq0[0].withdraw) begin
                void'(dq0.pop_front()); dcnt0 = (dq0.size() > 0) ? dq0[0].gap : 0;
            end else if (!p0 && dq0.size() > 0 && dcnt0 > 0) dcnt0--;
            if (Gnt1 && dq1.size() > 0) begin
                void'(dq1.pop_front()); dcnt1 = (dq1.size() > 0) ? dq1[0].gap : 0;
            end else if (p1 && dq1[0].withdraw) begin
                void'(dq1.pop_front()); dcnt1 = (dq1.size() > 0) ? dq1[0].gap : 0;
            end else if (!p1 && dq1.size() > 0 && dcnt1 > 0) dcnt1--;

            @(posedge CLK); #1;
            c++;
        end
        n_log = c;
        Req0 = 1'b0; Req1 = 1'b0;
        total++;
        if (c >= MAXC) begin
            bad++;
            $display("FAIL run_bound cycles=%0d required_below=%0d", c, MAXC);
        end
        q0.delete(); q1.delete();
    endtask

    task automatic test_reset();
        RST = 1'b0;
        Req0 = 1'b1; Req1 = 1'b1; We0 = 1'b1; Addr0 = 4'd3; WData0 = 16'hFFFF;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        total++;
        if ({Gnt0, Gnt1, RdValid0, RdValid1, Err0, Err1, RF_WrEn, RF_RdEn} !== 8'b0) begin
            bad++;
            $display("FAIL reset_strobes got=%b want=00000000",
                     {Gnt0, Gnt1, RdValid0, RdValid1, Err0, Err1, RF_WrEn, RF_RdEn});
        end
        total++;
        if ({RdData0, RdData1, RF_WrData, RF_Address} !== 52'h0) begin
            bad++;
            $display("FAIL reset_buses got=%h want=0", {RdData0, RdData1, RF_WrData, RF_Address});
        end
        Req0 = 1'b0; Req1 = 1'b0;
        @(posedge CLK); #1;
        RST = 1'b1;
        ref_reset();
        @(posedge CLK); #1;
        $display("test_reset: done");
    endtask

    task automatic test_write_read();
        int hits = 0;
        q0.push_back(mk(1, 3, 16'hA5A5, 0, 0));
        q0.push_back(mk(0, 3, 16'h0000, 0, 0));
        run();
        for (int i = 0; i < n_log; i++) begin
            total++;
            if (obs_log[i] !== exp_log[i]) begin
                bad++;
                $display("FAIL wr_rd cyc=%0d got=%h want=%h", i, obs_log[i], exp_log[i]);
            end
            if (obs_log[i].rdv0 && obs_log[i].rd0 == 16'hA5A5) hits++;
        end
        total++;
        if (hits != 1) begin bad++; $display("FAIL wr_rd_data hits=%0d want=1", hits); end
        total++;
        if (gnt_seq != '{0, 0}) begin bad++; $display("FAIL wr_rd_order got=%p want=0,0", gnt_seq); end
        $display("test_write_read: %0d cycles", n_log);
    endtask

    task automatic test_both_read();
        int hits = 0;
        q1.push_back(mk(1, 5, 16'h1234, 0, 0));
        q1.push_back(mk(0, 5, 16'h0000, 1, 0));
        q0.push_back(mk(0, 5, 16'h0000, 2, 0));
        run();
        for (int i = 0; i < n_log; i++) begin
            total++;
            if (obs_log[i] !== exp_log[i]) begin
                bad++;
                $display("FAIL both_rd cyc=%0d got=%h want=%h", i, obs_log[i], exp_log[i]);
            end
            if ((obs_log[i].rdv0 && obs_log[i].rd0 == 16'h1234) ||
                (obs_log[i].rdv1 && obs_log[i].rd1 == 16'h1234)) hits++;
        end
        total++;
        if (hits != 2) begin bad++; $display("FAIL both_rd_data hits=%0d want=2", hits); end
        total++;
        if (gnt_seq != '{1, 0, 1}) begin bad++; $display("FAIL both_rd_order got=%p want=1,0,1", gnt_seq); end
        $display("test_both_read: %0d cycles", n_log);
    endtask

    task automatic test_alternate();
        for (int i = 0; i < 3; i++) begin
            q0.push_back(mk($urandom_range(0, 1), $urandom_range(0, 7), $urandom, 0, 0));
            q1.push_back(mk($urandom_range(0, 1), $urandom_range(0, 7), $urandom, 0, 0));
        end
        run();
        for (int i = 0; i < n_log; i++) begin
            total++;
            if (obs_log[i] !== exp_log[i]) begin
                bad++;
                $display("FAIL alt cyc=%0d got=%h want=%h", i, obs_log[i], exp_log[i]);
            end
        end
        total++;
        if (gnt_seq != '{0, 1, 0, 1, 0, 1}) begin
            bad++; $display("FAIL alt_order got=%p want=0,1,0,1,0,1", gnt_seq);
        end
        $display("test_alternate: %0d cycles", n_log);
    endtask

    task automatic test_bad_addr();
        int wr = 0, rd = 0, er = 0;
        q1.push_back(mk(1, 9, $urandom, 0, 0));
        q0.push_back(mk(0, 1, 16'h0000, 2, 0));
        run();
        for (int i = 0; i < n_log; i++) begin
            total++;
            if (obs_log[i] !== exp_log[i]) begin
                bad++;
                $display("FAIL bad_addr cyc=%0d got=%h want=%h", i, obs_log[i], exp_log[i]);
            end
            if (obs_log[i].wren) wr++;
            if (obs_log[i].rden) rd++;
            if (obs_log[i].err1) er++;
        end
        total++;
        if (wr != 0 || rd != 1 || er != 1) begin
            bad++; $display("FAIL bad_addr_counts wren=%0d rden=%0d err1=%0d want=0,1,1", wr, rd, er);
        end
        $display("test_bad_addr: %0d cycles", n_log);
    endtask

    task automatic test_reset_midflight();
        Req0 = 1'b1; We0 = 1'b0; Addr0 = 4'd2;
        @(negedge CLK);
        total++;
        if (Gnt0 !== 1'b1) begin bad++; $display("FAIL mid_gnt got=%b want=1", Gnt0); end
        @(posedge CLK); #1;
        Req0 = 1'b0;
        RST = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge CLK);
            total++;
            if ({Gnt0, Gnt1, RdValid0, RdValid1, Err0, Err1, RF_WrEn, RF_RdEn,
                 RdData0, RdData1, RF_WrData, RF_Address} !== 60'h0) begin
                bad++;
                $display("FAIL mid_reset_outputs k=%0d got=%h want=0", k,
                         {Gnt0, Gnt1, RdValid0, RdValid1, Err0, Err1, RF_WrEn, RF_RdEn,
                          RdData0, RdData1, RF_WrData, RF_Address});
            end
        end
        @(posedge CLK); #1;
        RST = 1'b1;
        ref_reset();
        q0.push_back(mk(0, 7, 16'h0000, 0, 0));
        q1.push_back(mk(0, 7, 16'h0000, 0, 0));
        run();
        for (int i = 0; i < n_log; i++) begin
            total++;
            if (obs_log[i] !== exp_log[i]) begin
                bad++;
                $display("FAIL mid_after cyc=%0d got=%h want=%h", i, obs_log[i], exp_log[i]);
            end
        end
        total++;
        if (gnt_seq != '{0, 1}) begin bad++; $display("FAIL mid_ptr got=%p want=0,1", gnt_seq); end
        $display("test_reset_midflight: %0d cycles", n_log);
    endtask

    task automatic test_random();
        for (int i = 0; i < 20; i++) begin
            q0.push_back(mk($urandom_range(0, 1), $urandom_range(0, 10), $urandom,
                            $urandom_range(0, 3), $urandom_range(0, 7) == 0));
            q1.push_back(mk($urandom_range(0, 1), $urandom_range(0, 10), $urandom,
                            $urandom_range(0, 3), $urandom_range(0, 7) == 0));
        end
        run();
        for (int i = 0; i < n_log; i++) begin
            total++;
            if (obs_log[i] !== exp_log[i]) begin
                bad++;
                $display("FAIL random cyc=%0d got=%h want=%h", i, obs_log[i], exp_log[i]);
            end
        end
        $display("test_random: %0d cycles, %0d grants", n_log, gnt_seq.size());
    endtask

    task automatic test_back_to_back();
        int hits = 0;
        q0.push_back(mk(1, 7, 16'hFFFF, 0, 0));
        q1.push_back(mk(0, 7, 16'h0000, 1, 0));
        run();
        for (int i = 0; i < n_log; i++) begin
            total++;
            if (obs_log[i] !== exp_log[i]) begin
                bad++;
                $display("FAIL b2b cyc=%0d got=%h want=%h", i, obs_log[i], exp_log[i]);
            end
            if (obs_log[i].rdv1 && obs_log[i].rd1 == 16'hFFFF) hits++;
        end
        total++;
        if (hits != 1) begin bad++; $display("FAIL b2b_data hits=%0d want=1", hits); end
        total++;
        if (both_seen !== 1'b0) begin bad++; $display("FAIL wren_rden_excl got=%b want=0", both_seen); end
        $display("test_back_to_back: %0d cycles", n_log);
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_both_read();
        test_alternate();
        test_bad_addr();
        test_reset_midflight();
        test_random();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
